// File: rtl/adc78h90_seq.sv
// adc78h90_seq: round-robin channel scanner for an ADC78H90 SPI converter.
// Each frame requests the next channel and collects the result of the previous request.
module adc78h90_seq #(
  parameter int CLK_DIV = 8,
  parameter int NCH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        ADCMISO,
  output logic        ADCCLK,
  output logic        ADCMOSI,
  output logic        nADCCS,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_chan,
  output logic        sample_valid,
  output logic        busy
);
  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);
  localparam logic [2:0] LAST = 3'(NCH - 1);
  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;
  state_t      state;
  logic [7:0]  hcnt;
  logic [3:0]  bcnt;
  logic        hi, prime, hend, unused;
  logic [2:0]  req_ch, pend_ch;
  logic [15:0] shift, din;
  assign hend = hcnt == HMAX;
  assign din = {2'b00, req_ch, 11'd0};
  // the converter's four leading zero bits carry no information
  assign unused = ^shift[15:12];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      nADCCS       <= 1'b1;
      ADCCLK       <= 1'b1;
      ADCMOSI      <= 1'b0;
      sample_data  <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      req_ch       <= '0;
      pend_ch      <= '0;
      prime        <= 1'b0;
      hcnt         <= '0;
      bcnt         <= '0;
      hi           <= 1'b0;
      shift        <= '0;
    end else begin
      sample_valid <= 1'b0;
      hcnt <= (state == IDLE || hend) ? '0 : hcnt + 8'd1;
      case (state)
        IDLE: if (run) begin
          state  <= START;
          nADCCS <= 1'b0;
          busy   <= 1'b1;
          prime  <= 1'b0;
        end
        START: if (hend) begin
          state   <= SHIFT;
          ADCCLK  <= 1'b0;
          ADCMOSI <= din[15];
          bcnt    <= '0;
          hi      <= 1'b0;
        end
        SHIFT: if (hend) begin
          if (!hi) begin
            ADCCLK <= 1'b1;
            hi     <= 1'b1;
            shift  <= {shift[14:0], ADCMISO};
          end else if (bcnt == 4'd15) begin
            state   <= STOP;
            nADCCS  <= 1'b1;
            bcnt    <= '0;
            hi      <= 1'b0;
            pend_ch <= req_ch;
            req_ch  <= (req_ch == LAST) ? '0 : req_ch + 3'd1;
            prime   <= 1'b1;
            if (prime) begin
              sample_data  <= shift[11:0];
              sample_chan  <= pend_ch;
              sample_valid <= 1'b1;
            end
          end else begin
            bcnt    <= bcnt + 4'd1;
            hi      <= 1'b0;
            ADCCLK  <= 1'b0;
            ADCMOSI <= din[4'd14 - bcnt];
          end
        end
        STOP: if (hend) begin
          state  <= run ? START : IDLE;
          nADCCS <= !run;
          busy   <= run;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc78h90_seq.sv
// tb_adc78h90_seq: directed bench with a converter model for two parameter sets.
module tb_adc78h90_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n = 1'b0, run = 1'b0, adcmiso = 1'b0;
  logic adcclk, adcmosi, nadccs, sample_valid, busy;
  logic [11:0] sample_data;
  logic [2:0]  sample_chan;
  adc78h90_seq #(.CLK_DIV(8), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ADCMISO(adcmiso), .ADCCLK(adcclk),
    .ADCMOSI(adcmosi), .nADCCS(nadccs), .sample_data(sample_data),
    .sample_chan(sample_chan), .sample_valid(sample_valid), .busy(busy));

  logic rst_b = 1'b0, run_b = 1'b0, adcmiso_b = 1'b0;
  logic adcclk_b, adcmosi_b, nadccs_b, sv_b, busy_b;
  logic [11:0] sd_b;
  logic [2:0]  sc_b;
  adc78h90_seq #(.CLK_DIV(2), .NCH(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .run(run_b), .ADCMISO(adcmiso_b), .ADCCLK(adcclk_b),
    .ADCMOSI(adcmosi_b), .nADCCS(nadccs_b), .sample_data(sd_b),
    .sample_chan(sc_b), .sample_valid(sv_b), .busy(busy_b));

  int nvec = 0, nbad = 0;
  task automatic chk(string nm, int got, int exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // converter result for a channel (top nibble deliberately nonzero)
  function automatic logic [11:0] conv(logic [2:0] c);
    return (c == 3'd0) ? 12'hABC : {1'b0, c, 8'hBC};
  endfunction

  typedef struct {int tf; int tr; logic [15:0] din; int rises; bit bad;} frame_t;
  typedef struct {int t; logic [11:0] d; logic [2:0] c;} smp_t;
  frame_t fq[$];
  smp_t   vq[$];
  int cur_rises = 0, last_edge = 0, bitn = 0, tf_cur = 0, vbad = 0;
  logic [15:0] din_cap = '0, miso_word = '0;
  bit fbad = 0;
  logic p_cs = 1'b1, p_clk = 1'b1, p_mosi = 1'b0, p_valid = 1'b0;

  function automatic frame_t fget(int k);
    frame_t z = '{-1, -1, 16'hFFFF, -1, 1'b1};
    return (k < fq.size()) ? fq[k] : z;
  endfunction
  function automatic smp_t vget(int k);
    smp_t z = '{-1, 12'hFFF, 3'h7};
    return (k < vq.size()) ? vq[k] : z;
  endfunction

  // converter model and frame monitor for the CLK_DIV=8 instance
  always @(negedge clk) begin
    if (p_cs && !nadccs) begin
      tf_cur = cyc; din_cap = '0; cur_rises = 0; bitn = 0; fbad = 0; last_edge = cyc;
    end
    if (!nadccs && p_clk && !adcclk) begin
      if (cyc - last_edge != 8) fbad = 1;
      adcmiso = (bitn < 16) ? miso_word[15 - bitn] : 1'b0;
      bitn++; last_edge = cyc;
    end
    if (!nadccs && !p_clk && adcclk) begin
      if (cyc - last_edge != 8) fbad = 1;
      din_cap = {din_cap[14:0], adcmosi};
      cur_rises++; last_edge = cyc;
    end
    if (!nadccs && !p_cs && p_clk && adcclk && adcmosi !== p_mosi) fbad = 1;
    if (nadccs && !p_cs) begin
      if (cur_rises == 16 && cyc - last_edge != 8) fbad = 1;
      fq.push_back('{tf_cur, cyc, din_cap, cur_rises, fbad});
      miso_word = {4'hA, conv(din_cap[13:11])};
    end
    if (sample_valid) begin
      vq.push_back('{cyc, sample_data, sample_chan});
      if (p_valid) vbad++;
    end
    p_cs = nadccs; p_clk = adcclk; p_mosi = adcmosi; p_valid = sample_valid;
  end

  // lighter monitor for the NCH=1, CLK_DIV=2 instance
  int fb_t[$];
  logic [15:0] fb_din[$];
  smp_t vbq[$];
  logic [15:0] dcap_b = '0, word_b = {4'hA, 12'hABC};
  int bitb = 0;
  logic pcs_b = 1'b1, pclk_b = 1'b1;
  always @(negedge clk) begin
    if (pcs_b && !nadccs_b) begin fb_t.push_back(cyc); dcap_b = '0; bitb = 0; end
    if (!nadccs_b && pclk_b && !adcclk_b) begin
      adcmiso_b = (bitb < 16) ? word_b[15 - bitb] : 1'b0;
      bitb++;
    end
    if (!nadccs_b && !pclk_b && adcclk_b) dcap_b = {dcap_b[14:0], adcmosi_b};
    if (nadccs_b && !pcs_b) fb_din.push_back(dcap_b);
    if (sv_b) vbq.push_back('{cyc, sd_b, sc_b});
    pcs_b = nadccs_b; pclk_b = adcclk_b;
  end

  task automatic wait_frames(int n, int budget);
    for (int i = 0; i < budget && fq.size() < n; i++) @(negedge clk);
    chk($sformatf("frames reached %0d", n), int'(fq.size() >= n), 1);
  endtask

  task automatic wait_bit(int nf, int nb);
    for (int i = 0; i < 3000 && !(fq.size() >= nf && !nadccs && cur_rises == nb); i++)
      @(negedge clk);
    chk($sformatf("reach bit %0d after %0d frames", nb, nf),
        int'(fq.size() >= nf && !nadccs && cur_rises == nb), 1);
  endtask

  typedef struct {logic [2:0] req; logic [2:0] chan; logic [11:0] data;} vec_t;
  vec_t tbl[6];
  string rname[7];
  int rgot[7], rexp[7];
  frame_t f;
  smp_t v;
  int fb, vb;

  initial begin
    tbl = '{'{3'd0, 3'd0, 12'h000}, '{3'd1, 3'd0, 12'hABC}, '{3'd2, 3'd1, 12'h1BC},
            '{3'd3, 3'd2, 12'h2BC}, '{3'd0, 3'd3, 12'h3BC}, '{3'd1, 3'd0, 12'hABC}};
    rname = '{"rst nADCCS", "rst ADCCLK", "rst ADCMOSI", "rst sample_data",
              "rst sample_chan", "rst sample_valid", "rst busy"};
    rexp = '{1, 1, 0, 0, 0, 0, 0};
    // reset state
    repeat (3) @(negedge clk);
    rgot = '{int'(nadccs), int'(adcclk), int'(adcmosi), int'(sample_data),
             int'(sample_chan), int'(sample_valid), int'(busy)};
    for (int i = 0; i < 7; i++) chk(rname[i], rgot[i], rexp[i]);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle busy", int'(busy), 0);
    chk("idle nADCCS", int'(nadccs), 1);
    // start: CS falls exactly one edge after run is seen
    @(posedge clk); #1 run = 1'b1;
    @(negedge clk); chk("CS before run edge", int'(nadccs), 1);
    @(negedge clk); chk("CS after run edge", int'(nadccs), 0);
    chk("busy after run", int'(busy), 1);
    wait_frames(6, 2200);
    @(negedge clk);
    chk("valids in 6 frames", vq.size(), 5);
    chk("first valid offset", vget(0).t - fget(0).tf, 536);
    for (int i = 0; i < 6; i++) begin
      f = fget(i);
      chk($sformatf("A din f%0d", i), f.din, {2'b00, tbl[i].req, 11'd0});
      chk($sformatf("A rises f%0d", i), f.rises, 16);
      chk($sformatf("A timing f%0d", i), int'(f.bad), 0);
      chk($sformatf("A cs low f%0d", i), f.tr - f.tf, 264);
      if (i > 0) begin
        chk($sformatf("A period f%0d", i), f.tf - fget(i - 1).tf, 272);
        v = vget(i - 1);
        chk($sformatf("A chan f%0d", i), v.c, tbl[i].chan);
        chk($sformatf("A data f%0d", i), v.d, tbl[i].data);
        chk($sformatf("A valid time f%0d", i), v.t, f.tr);
      end
    end
    // run dropped mid frame 3
    @(posedge clk); #1 rst_n = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    fq.delete(); vq.delete();
    @(posedge clk); #1 rst_n = 1'b1; run = 1'b1;
    wait_bit(2, 5);
    run = 1'b0;
    wait_frames(3, 600);
    repeat (300) @(negedge clk);
    chk("B frames", fq.size(), 3);
    chk("B din f2", fget(2).din, {2'b00, 3'd2, 11'd0});
    chk("B rises f2", fget(2).rises, 16);
    chk("B valids", vq.size(), 2);
    chk("B last chan", vget(1).c, 1);
    chk("B last data", vget(1).d, 12'h1BC);
    chk("B last valid time", vget(1).t, fget(2).tr);
    chk("B idle busy", int'(busy), 0);
    chk("B idle nADCCS", int'(nadccs), 1);
    // resume: scan continues at channel 3, priming frame discarded
    run = 1'b1;
    wait_frames(5, 900);
    @(negedge clk);
    chk("C din f3", fget(3).din, {2'b00, 3'd3, 11'd0});
    chk("C din f4", fget(4).din, 16'h0000);
    chk("C valids", vq.size(), 3);
    chk("C chan", vget(2).c, 3);
    chk("C data", vget(2).d, 12'h3BC);
    chk("C valid time", vget(2).t, fget(4).tr);
    // run dropped then restored during STOP
    wait_bit(5, 3);
    run = 1'b0;
    for (int i = 0; i < 600 && fq.size() < 6; i++) @(negedge clk);
    run = 1'b1;
    wait_frames(8, 900);
    @(negedge clk);
    chk("D period", fget(6).tf - fget(5).tf, 272);
    chk("D din f6", fget(6).din, {2'b00, 3'd2, 11'd0});
    chk("D valids", vq.size(), 6);
    chk("D chan", vget(4).c, 1);
    chk("D data", vget(4).d, 12'h1BC);
    chk("D valid time", vget(4).t, fget(6).tr);
    // one-cycle reset at bit 9
    wait_bit(8, 9);
    fb = fq.size(); vb = vq.size();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("E nADCCS", int'(nadccs), 1);
    chk("E ADCCLK", int'(adcclk), 1);
    chk("E busy", int'(busy), 0);
    chk("E valid", int'(sample_valid), 0);
    chk("E sample_data", int'(sample_data), 0);
    wait_frames(fb + 3, 1000);
    @(negedge clk);
    chk("E restart gap", fget(fb + 1).tf - fget(fb).tr, 1);
    chk("E din restart", fget(fb + 1).din, 16'h0000);
    chk("E din next", fget(fb + 2).din, {2'b00, 3'd1, 11'd0});
    chk("E valids", vq.size(), vb + 1);
    chk("E chan", vget(vb).c, 0);
    chk("E data", vget(vb).d, 12'hABC);
    chk("E valid time", vget(vb).t, fget(fb + 2).tr);
    run = 1'b0;
    // NCH=1, CLK_DIV=2 instance
    @(posedge clk); #1 rst_b = 1'b1; run_b = 1'b1;
    for (int i = 0; i < 500 && fb_din.size() < 5; i++) @(negedge clk);
    chk("F frames", int'(fb_din.size() >= 5), 1);
    for (int i = 1; i < 5 && i < fb_t.size(); i++)
      chk($sformatf("F period %0d", i), fb_t[i] - fb_t[i - 1], 68);
    for (int i = 0; i < 5 && i < fb_din.size(); i++)
      chk($sformatf("F din %0d", i), fb_din[i], 16'h0000);
    chk("F valids", int'(vbq.size() >= 3), 1);
    for (int i = 0; i < vbq.size(); i++) begin
      chk($sformatf("F chan %0d", i), vbq[i].c, 0);
      chk($sformatf("F data %0d", i), vbq[i].d, 12'hABC);
    end
    chk("valid pulse width", vbad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
